// File: rtl/wb_stage_if.sv
// ---------------------------------------------------------------------------
// wb_stage_if -- MEM->WB handshake and payload bundle.
//
// Signals:
//   in_valid        MEM stage presents an instruction
//   in_ready        WB stage accepts it this cycle
//   pc              instruction PC
//   result          ALU/mul/div result, or load address for loads
//   load_op         one-hot {SW,SH,SB,LW,LHU,LH,LBU,LB}
//   res_from_mem    writeback data comes from data SRAM
//   gr_we           register write enable
//   dest            destination register
//   data_sram_rdata SRAM read data for loads
//
// Modports: master = MEM side (drives payload), slave = WB side.
// ---------------------------------------------------------------------------
interface wb_stage_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [31:0] result;
  logic [7:0]  load_op;
  logic        res_from_mem;
  logic        gr_we;
  logic [4:0]  dest;
  logic [31:0] data_sram_rdata;

  modport master (
    output in_valid, pc, result, load_op, res_from_mem, gr_we, dest,
           data_sram_rdata,
    input  in_ready
  );

  modport slave (
    input  in_valid, pc, result, load_op, res_from_mem, gr_we, dest,
           data_sram_rdata,
    output in_ready
  );
endinterface

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- pipeline writeback stage.
//
// Retires one instruction per MEM->WB handshake with no added latency:
// extracts and extends load data, drives the regfile write port and the
// forwarding bus, counts retired instructions and emits a trace entry.
// Load data that arrives while WB is stalled is captured so a changing SRAM
// read bus cannot corrupt the pending load.
//
// Ports:
//   clk, resetn         clock, synchronous active-low reset
//   mw (slave)          MEM->WB handshake/payload bundle (wb_stage_if)
//   rf_we/waddr/wdata   regfile write port
//   fwd_valid/dest/data pending write for hazard detection / forwarding
//   instret             retired-instruction counter (wraps)
//   debug_wb_*          trace entry {pc, byte enables, reg number, data}
//   trace_valid/ready   trace handshake
//
// Configuration macro: WB_TRACE_FIFO_EN
//   defined   -> 4-entry trace FIFO; WB stalls when full and not draining
//   undefined -> trace is the current retiring instruction; never stalls
// ---------------------------------------------------------------------------
module wb_stage (
  input  logic             clk,
  input  logic             resetn,
  wb_stage_if.slave        mw,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             fwd_valid,
  output logic [4:0]       fwd_dest,
  output logic [31:0]      fwd_data,
  output logic [31:0]      instret,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_we,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata,
  output logic             trace_valid,
  input  logic             trace_ready
);

  // Trace entry layout: {pc[72:41], we[40:37], wnum[36:32], data[31:0]}
  localparam int unsigned TR_W = 73;

  // Select the addressed byte/half from a load word and extend it.
  // Unaligned half offsets (1/3) fall back to the half at offset 0/2.
  function automatic logic [31:0] load_extract(
    input logic [7:0]  op,
    input logic [1:0]  off,
    input logic [31:0] word
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    if (off[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    if (op[0]) begin
      r = {{24{b[7]}}, b};
    end else if (op[1]) begin
      r = {24'h00_0000, b};
    end else if (op[2]) begin
      r = {{16{h[15]}}, h};
    end else if (op[3]) begin
      r = {16'h0000, h};
    end else begin
      r = word;
    end
    return r;
  endfunction

  logic              ready_go_s;
  logic              in_ready_s;
  logic              fire_s;
  logic              wr_en_s;
  logic [31:0]       ld_word_s;
  logic [31:0]       final_data_s;
  logic [TR_W-1:0]   trace_entry_s;
  logic [TR_W-1:0]   trace_out_s;

  logic              hold_vld_q, hold_vld_d;
  logic [31:0]       hold_word_q, hold_word_d;
  logic [31:0]       instret_q, instret_d;

  // Handshake, load data path and regfile/forwarding outputs
  always_comb begin
    in_ready_s   = resetn & (~mw.in_valid | ready_go_s);
    fire_s       = mw.in_valid & in_ready_s;
    wr_en_s      = mw.gr_we & (mw.dest != 5'd0);
    if (hold_vld_q) begin
      ld_word_s = hold_word_q;
    end else begin
      ld_word_s = mw.data_sram_rdata;
    end
    if (mw.res_from_mem) begin
      final_data_s = load_extract(mw.load_op, mw.result[1:0], ld_word_s);
    end else begin
      final_data_s = mw.result;
    end
    trace_entry_s = {mw.pc, {4{fire_s & wr_en_s}}, mw.dest, final_data_s};
  end

  assign mw.in_ready = in_ready_s;
  assign rf_we       = fire_s & wr_en_s;
  assign rf_waddr    = mw.dest;
  assign rf_wdata    = final_data_s;
  assign fwd_valid   = mw.in_valid & wr_en_s;
  assign fwd_dest    = mw.dest;
  assign fwd_data    = final_data_s;
  assign instret     = instret_q;

  // Next state for the load-data hold register and retire counter.
  // Capture only on the first stalled cycle so later SRAM bus changes are
  // ignored until the load retires.
  always_comb begin
    hold_vld_d  = hold_vld_q;
    hold_word_d = hold_word_q;
    instret_d   = instret_q;
    if (fire_s) begin
      hold_vld_d = 1'b0;
      instret_d  = instret_q + 32'd1;
    end else if (mw.in_valid & mw.res_from_mem & ~hold_vld_q) begin
      hold_vld_d  = 1'b1;
      hold_word_d = mw.data_sram_rdata;
    end else begin
      hold_vld_d = hold_vld_q;
    end
  end

  // Hold register and retire counter state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hold_vld_q  <= 1'b0;
      hold_word_q <= 32'h0000_0000;
      instret_q   <= 32'h0000_0000;
    end else begin
      hold_vld_q  <= hold_vld_d;
      hold_word_q <= hold_word_d;
      instret_q   <= instret_d;
    end
  end

`ifdef WB_TRACE_FIFO_EN
  logic [TR_W-1:0]   fifo_q [4];
  logic [TR_W-1:0]   fifo_d [4];
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [2:0]        count_q, count_d;
  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;

  // FIFO control. A push into a full FIFO is only possible when the head
  // is popped in the same cycle, so count stays within 0..4.
  always_comb begin
    full_s     = (count_q == 3'd4);
    empty_s    = (count_q == 3'd0);
    push_s     = fire_s;
    pop_s      = ~empty_s & trace_ready;
    ready_go_s = ~full_s | trace_ready;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + {2'b00, push_s} - {2'b00, pop_s};
    if (push_s) begin
      fifo_d[wr_ptr_q] = trace_entry_s;
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 2'd1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (empty_s) begin
      trace_out_s = {TR_W{1'b0}};
    end else begin
      trace_out_s = fifo_q[rd_ptr_q];
    end
  end

  // FIFO pointer and occupancy state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; stale contents are masked by the empty check
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign trace_valid = ~empty_s;
`else
  logic unused_trace_ready_s;

  // Without a FIFO the trace shows the retiring instruction, zero otherwise
  always_comb begin
    ready_go_s           = 1'b1;
    unused_trace_ready_s = trace_ready;
    if (fire_s) begin
      trace_out_s = trace_entry_s;
    end else begin
      trace_out_s = {TR_W{1'b0}};
    end
  end

  assign trace_valid = fire_s;
`endif

  assign debug_wb_pc       = trace_out_s[72:41];
  assign debug_wb_rf_we    = trace_out_s[40:37];
  assign debug_wb_rf_wnum  = trace_out_s[36:32];
  assign debug_wb_rf_wdata = trace_out_s[31:0];

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage -- scoreboard bench for wb_stage.
// Issued instructions push expected regfile writes and trace entries into
// queues; a negedge monitor pops and compares whenever the DUT retires an
// instruction or hands out a trace entry.
// ---------------------------------------------------------------------------
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        trace_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
  logic [31:0] instret;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        trace_valid;

  wb_stage_if mw ();

  wb_stage dut (
    .clk               (clk),
    .resetn            (resetn),
    .mw                (mw.slave),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .fwd_valid         (fwd_valid),
    .fwd_dest          (fwd_dest),
    .fwd_data          (fwd_data),
    .instret           (instret),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .trace_valid       (trace_valid),
    .trace_ready       (trace_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] result;
    logic [7:0]  op;
    logic        rfm;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] rdata;
    logic [31:0] exp_data;
    logic        exp_we;
  } vec_t;

  vec_t        vecs[$];
  logic [37:0] rf_q[$];   // {we, waddr, wdata}
  logic [72:0] tr_q[$];   // {pc, we x4, wnum, wdata}
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_instret = 32'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] pc, input logic [31:0] result,
                         input logic [7:0] op, input logic rfm, input logic gr_we,
                         input logic [4:0] dest, input logic [31:0] rdata,
                         input logic [31:0] exp_data, input logic exp_we);
    vec_t v;
    v.pc = pc; v.result = result; v.op = op; v.rfm = rfm; v.gr_we = gr_we;
    v.dest = dest; v.rdata = rdata; v.exp_data = exp_data; v.exp_we = exp_we;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    mw.pc              = v.pc;
    mw.result          = v.result;
    mw.load_op         = v.op;
    mw.res_from_mem    = v.rfm;
    mw.gr_we           = v.gr_we;
    mw.dest            = v.dest;
    mw.data_sram_rdata = v.rdata;
    mw.in_valid        = 1'b1;
  endtask

  task automatic expect_vec(input vec_t v);
    rf_q.push_back({v.exp_we, v.dest, v.exp_data});
    tr_q.push_back({v.pc, {4{v.exp_we}}, v.dest, v.exp_data});
  endtask

  // Present one instruction and hold it until it is accepted (bounded)
  task automatic issue(input vec_t v);
    logic fired;
    fired = 1'b0;
    drive(v);
    expect_vec(v);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (mw.in_ready) begin
        fired = 1'b1;
        break;
      end
    end
    chk("issue_accept", {127'd0, fired}, 128'd1);
    @(posedge clk);
    #1;
    mw.in_valid = 1'b0;
    if (fired) exp_instret = exp_instret + 32'd1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mw.in_valid && mw.in_ready) begin
      if (rf_q.size() == 0) begin
        chk("rf_unexpected", 128'd1, 128'd0);
      end else begin
        logic [37:0] e;
        e = rf_q.pop_front();
        chk("rf_write", {90'd0, rf_we, rf_waddr, rf_wdata}, {90'd0, e});
        chk("fwd_bus", {90'd0, fwd_valid, fwd_dest, fwd_data}, {90'd0, e});
      end
    end
    if (trace_valid && trace_ready) begin
      if (tr_q.size() == 0) begin
        chk("trace_unexpected", 128'd1, 128'd0);
      end else begin
        logic [72:0] t;
        t = tr_q.pop_front();
        chk("trace_entry",
            {55'd0, debug_wb_pc, debug_wb_rf_we, debug_wb_rf_wnum, debug_wb_rf_wdata},
            {55'd0, t});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    resetn             = 1'b0;
    trace_ready        = 1'b1;
    mw.in_valid        = 1'b0;
    mw.pc              = 32'h0;
    mw.result          = 32'h0;
    mw.load_op         = 8'h00;
    mw.res_from_mem    = 1'b0;
    mw.gr_we           = 1'b0;
    mw.dest            = 5'd0;
    mw.data_sram_rdata = 32'h0;

    add_vec(32'h1C00_0000, 32'h1000_0003, 8'h01, 1'b1, 1'b1, 5'd5,  32'h80FF_1234, 32'hFFFF_FF80, 1'b1);
    add_vec(32'h1C00_0004, 32'h1000_0002, 8'h08, 1'b1, 1'b1, 5'd6,  32'h8001_0000, 32'h0000_8001, 1'b1);
    add_vec(32'h1C00_0008, 32'h1000_0002, 8'h04, 1'b1, 1'b1, 5'd7,  32'h8001_0000, 32'hFFFF_8001, 1'b1);
    add_vec(32'h1C00_000C, 32'h1000_0001, 8'h02, 1'b1, 1'b1, 5'd8,  32'h80FF_1234, 32'h0000_0012, 1'b1);
    add_vec(32'h1C00_0010, 32'h1000_0002, 8'h01, 1'b1, 1'b1, 5'd9,  32'h80FF_1234, 32'hFFFF_FFFF, 1'b1);
    add_vec(32'h1C00_0014, 32'h1000_0000, 8'h02, 1'b1, 1'b1, 5'd10, 32'h80FF_1234, 32'h0000_0034, 1'b1);
    add_vec(32'h1C00_0018, 32'h1000_0001, 8'h04, 1'b1, 1'b1, 5'd11, 32'h1234_8765, 32'hFFFF_8765, 1'b1);
    add_vec(32'h1C00_001C, 32'h1000_0003, 8'h08, 1'b1, 1'b1, 5'd12, 32'h8765_ABCD, 32'h0000_8765, 1'b1);
    add_vec(32'h1C00_0020, 32'h0000_0020, 8'h10, 1'b1, 1'b1, 5'd13, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    add_vec(32'h1C00_0024, 32'h1234_5678, 8'h00, 1'b0, 1'b1, 5'd14, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    add_vec(32'h1C00_0028, 32'h0000_0100, 8'h80, 1'b0, 1'b0, 5'd3,  32'h0000_0000, 32'h0000_0100, 1'b0);
    add_vec(32'h1C00_002C, 32'h0000_0055, 8'h00, 1'b0, 1'b1, 5'd0,  32'h0000_0000, 32'h0000_0055, 1'b0);

    // Reset state with a writing instruction offered
    drive(vecs[0]);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",    {127'd0, mw.in_ready},  128'd0);
    chk("rst_rf_we",       {127'd0, rf_we},        128'd0);
    chk("rst_instret",     {96'd0, instret},       128'd0);
    chk("rst_trace_valid", {127'd0, trace_valid},  128'd0);
    chk("rst_trace_pc",    {96'd0, debug_wb_pc},   128'd0);
    @(posedge clk);
    #1;
    mw.in_valid = 1'b0;
    resetn      = 1'b1;
    @(negedge clk);
    chk("idle_trace_valid", {127'd0, trace_valid}, 128'd0);
    chk("idle_instret",     {96'd0, instret},      128'd0);
    @(posedge clk);
    #1;

    // Directed vectors; the last two (SW, ADD to r0) must not write
    for (int i = 0; i < vecs.size(); i++) begin
      if (i == 10) chk("instret_before_nowrite", {96'd0, instret}, {96'd0, exp_instret});
      issue(vecs[i]);
    end
    chk("instret_after_nowrite", {96'd0, instret}, {96'd0, exp_instret});
    chk("instret_count_12", {96'd0, exp_instret}, 128'd12);

    // Reset while an instruction is offered
    drive(vecs[1]);
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_instret",     {96'd0, instret},      128'd0);
    chk("mid_rst_in_ready",    {127'd0, mw.in_ready}, 128'd0);
    chk("mid_rst_trace_valid", {127'd0, trace_valid}, 128'd0);
    @(posedge clk);
    #1;
    mw.in_valid = 1'b0;
    resetn      = 1'b1;
    exp_instret = 32'd0;
    issue(vecs[2]);
    chk("post_rst_instret", {96'd0, instret}, {96'd0, exp_instret});

`ifdef WB_TRACE_FIFO_EN
    // Fill the trace FIFO, then stall a load and change the SRAM bus
    trace_ready = 1'b0;
    for (int i = 9; i < 12; i++) issue(vecs[i]);
    issue(vecs[9]);
    v = vecs[8];
    v.rdata    = 32'hAAAA_AAAA;
    v.exp_data = 32'hAAAA_AAAA;
    drive(v);
    expect_vec(v);
    @(negedge clk);
    chk("full_in_ready", {127'd0, mw.in_ready}, 128'd0);
    @(posedge clk);
    #1;
    mw.data_sram_rdata = 32'h5555_5555;
    @(negedge clk);
    chk("full_in_ready2", {127'd0, mw.in_ready}, 128'd0);
    @(posedge clk);
    #1;
    trace_ready = 1'b1;
    @(negedge clk);
    chk("drain_in_ready", {127'd0, mw.in_ready}, 128'd1);
    @(posedge clk);
    #1;
    mw.in_valid = 1'b0;
    exp_instret = exp_instret + 32'd1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain_trace_valid", {127'd0, trace_valid}, 128'd0);
    chk("fifo_instret", {96'd0, instret}, {96'd0, exp_instret});

    // Reset during a stalled load with captured data
    trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(vecs[9]);
    v = vecs[8];
    v.rdata = 32'hAAAA_AAAA;
    drive(v);
    @(negedge clk);
    chk("stall_in_ready", {127'd0, mw.in_ready}, 128'd0);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    tr_q.delete();
    mw.data_sram_rdata = 32'h5555_5555;
    @(posedge clk);
    @(negedge clk);
    chk("ld_rst_instret",     {96'd0, instret},      128'd0);
    chk("ld_rst_trace_valid", {127'd0, trace_valid}, 128'd0);
    chk("ld_rst_in_ready",    {127'd0, mw.in_ready}, 128'd0);
    @(posedge clk);
    #1;
    resetn      = 1'b1;
    trace_ready = 1'b1;
    exp_instret = 32'd0;
    v.rdata    = 32'h5555_5555;
    v.exp_data = 32'h5555_5555;
    issue(v);
    chk("ld_rst_after_instret", {96'd0, instret}, {96'd0, exp_instret});
    repeat (3) @(posedge clk);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rf_queue_empty", {96'd0, 32'(rf_q.size())}, 128'd0);
    chk("tr_queue_empty", {96'd0, 32'(tr_q.size())}, 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
